// File: rtl/axi_write_slot_arbiter.sv
// Per-slave AXI4 write-channel arbiter: round-robin grant held from AW
// through the W burst (WLAST) to the B response; exports the one-hot
// round-robin pointer and a completed-transaction counter.
module axi_write_slot_arbiter #(
   parameter int unsigned NUM_MASTER = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [NUM_MASTER-1:0] req,
   input  logic                  aw_hs,
   input  logic                  w_last_hs,
   input  logic                  b_hs,
   output logic [NUM_MASTER-1:0] grant,
   output logic                  grant_valid,
   output logic [NUM_MASTER-1:0] prio,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  txn_count
);

   localparam int unsigned IW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_MASTER-1:0] grant_q, grant_d;
   logic [NUM_MASTER-1:0] prio_q,  prio_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q,  w_done_d;
   logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;

   logic [NUM_MASTER-1:0] winner;
   logic [NUM_MASTER-1:0] grant_rot;
   logic [IW-1:0]         prio_idx;
   logic                  found;
   int unsigned           idx;

   // Round-robin pick: first requester scanning upward from the pointer, wrapping
   always_comb begin
      winner   = '0;
      found    = 1'b0;
      prio_idx = '0;
      idx      = 0;
      for (int unsigned i = 0; i < NUM_MASTER; i++) begin
         if (prio_q[i]) prio_idx = IW'(i);
      end
      for (int unsigned off = 0; off < NUM_MASTER; off++) begin
         idx = 32'(prio_idx) + off;
         if (idx >= NUM_MASTER) idx = idx - NUM_MASTER;
         if (!found && req[IW'(idx)]) begin
            winner[IW'(idx)] = 1'b1;
            found            = 1'b1;
         end
      end
   end

   // Grant rotated left by one; becomes the next pointer after completion
   always_comb begin
      grant_rot = '0;
      for (int unsigned i = 0; i < NUM_MASTER; i++) begin
         grant_rot[IW'((i + 1) % NUM_MASTER)] = grant_q[i];
      end
   end

   // Next-state logic for the transaction FSM, grant, pointer and counter
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      prio_d    = prio_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d   = winner;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            if ((aw_done_q | aw_hs) & (w_done_q | w_last_hs)) begin
               state_d = RESP;
            end else begin
               aw_done_d = aw_done_q | aw_hs;
               w_done_d  = w_done_q | w_last_hs;
            end
         end
         RESP: begin
            if (b_hs) begin
               state_d = IDLE;
               grant_d = '0;
               prio_d  = grant_rot;
               cnt_d   = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State registers with asynchronous reset
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         prio_q    <= NUM_MASTER'(1);
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         prio_q    <= prio_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         cnt_q     <= cnt_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign prio        = prio_q;
   assign busy        = (state_q != IDLE);
   assign txn_count   = cnt_q;

endmodule

// File: tb/tb_axi_write_slot_arbiter.sv
// Bench for axi_write_slot_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// transaction-level model (owner index, pointer index, handshake flags).
module tb_axi_write_slot_arbiter;

   localparam int N  = 4;
   localparam int CW = 16;

   logic          ACLK = 1'b0;
   logic          ARESET = 1'b1;
   logic [N-1:0]  req = '0;
   logic          aw_hs = 1'b0;
   logic          w_last_hs = 1'b0;
   logic          b_hs = 1'b0;
   logic [N-1:0]  grant;
   logic          grant_valid;
   logic [N-1:0]  prio;
   logic          busy;
   logic [CW-1:0] txn_count;

   int tests = 0;
   int fails = 0;
   int rst_pulses = 0;

   axi_write_slot_arbiter #(.NUM_MASTER(N), .CNT_WIDTH(CW)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .req(req), .aw_hs(aw_hs),
      .w_last_hs(w_last_hs), .b_hs(b_hs), .grant(grant),
      .grant_valid(grant_valid), .prio(prio), .busy(busy),
      .txn_count(txn_count)
   );

   always #5 ACLK = ~ACLK;

   // Model: owner = -1 when idle, else granted master index
   int       m_owner = -1;
   int       m_ptr   = 0;
   bit       m_aw    = 0;
   bit       m_w     = 0;
   bit       m_resp  = 0;
   int       m_cnt   = 0;
   int       seen_pulses = 0;

   function automatic logic [N-1:0] onehot(input int k);
      logic [N-1:0] v;
      v = '0;
      if (k >= 0) v[k] = 1'b1;
      return v;
   endfunction

   // Per-cycle comparison against the model, then advance the model
   always @(negedge ACLK) begin
      logic [N-1:0] eg;
      if (ARESET || seen_pulses != rst_pulses) begin
         seen_pulses = rst_pulses;
         m_owner = -1; m_ptr = 0; m_aw = 0; m_w = 0; m_resp = 0; m_cnt = 0;
      end
      eg = onehot(m_owner);
      tests++;
      if (grant !== eg || grant_valid !== (m_owner >= 0) || busy !== (m_owner >= 0) ||
          prio !== onehot(m_ptr) || txn_count !== CW'(m_cnt)) begin
         fails++;
         $display("FAIL model_cmp t=%0t: got grant=%b gv=%b busy=%b prio=%b cnt=%0d, want grant=%b gv=%b busy=%b prio=%b cnt=%0d",
                  $time, grant, grant_valid, busy, prio, txn_count,
                  eg, m_owner >= 0, m_owner >= 0, onehot(m_ptr), m_cnt % (1 << CW));
      end
      if (!ARESET) begin
         if (m_owner < 0) begin
            for (int off = 0; off < N; off++) begin
               int k;
               k = (m_ptr + off) % N;
               if (m_owner < 0 && req[k]) begin
                  m_owner = k; m_aw = 0; m_w = 0; m_resp = 0;
               end
            end
         end else if (!m_resp) begin
            if ((m_aw || aw_hs) && (m_w || w_last_hs)) m_resp = 1;
            else begin
               m_aw = m_aw || aw_hs;
               m_w  = m_w || w_last_hs;
            end
         end else if (b_hs) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_resp  = 0;
            m_cnt   = (m_cnt + 1) % (1 << CW);
         end
      end
   end

   // Apply inputs for one edge; returns at posedge+2 with outputs settled
   task automatic step(input logic [N-1:0] r, input logic a, input logic w, input logic b);
      req = r; aw_hs = a; w_last_hs = w; b_hs = b;
      @(posedge ACLK);
      #2;
   endtask

   task automatic lit(input string nm, input logic [N-1:0] eg, input logic [N-1:0] ep,
                      input int ec);
      tests++;
      if (grant !== eg || prio !== ep || txn_count !== CW'(ec)) begin
         fails++;
         $display("FAIL %s: got grant=%b prio=%b cnt=%0d, want grant=%b prio=%b cnt=%0d",
                  nm, grant, prio, txn_count, eg, ep, ec);
      end
   endtask

   initial begin
      logic [N-1:0] rr_exp [0:4];
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

      repeat (2) @(posedge ACLK);
      #2;
      ARESET = 1'b0;
      lit("reset", 4'b0000, 4'b0001, 0);

      // Async reset mid-RESP
      step(4'b0001, 0, 0, 0);
      lit("rst_txn_grant", 4'b0001, 4'b0001, 0);
      step(4'b0000, 1, 1, 0);
      ARESET = 1'b1;
      #1;
      lit("async_reset", 4'b0000, 4'b0001, 0);
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL async_reset_busy: got %b want 0", busy);
      end
      #1;
      ARESET = 1'b0;
      rst_pulses++;
      step(4'b0000, 0, 0, 1);
      lit("after_reset_b_ignored", 4'b0000, 4'b0001, 0);

      // Single request, separate handshakes
      step(4'b0100, 0, 0, 0);
      lit("single_grant", 4'b0100, 4'b0001, 0);
      step(4'b0000, 1, 0, 0);
      step(4'b0000, 0, 1, 0);
      step(4'b0000, 0, 0, 1);
      lit("single_done", 4'b0000, 4'b1000, 1);

      // Pointer skip and wrap, simultaneous AW+WLAST
      step(4'b0110, 0, 0, 0);
      lit("skip_grant", 4'b0010, 4'b1000, 1);
      step(4'b0000, 1, 1, 0);
      step(4'b0000, 0, 0, 1);
      lit("skip_done", 4'b0000, 4'b0100, 2);

      // WLAST before AW, b_hs during ADDR ignored, req dropped
      step(4'b1000, 0, 0, 0);
      step(4'b0000, 0, 1, 0);
      step(4'b0000, 0, 0, 1);
      lit("b_in_addr_ignored", 4'b1000, 4'b0100, 2);
      step(4'b0000, 1, 0, 0);
      lit("resp_hold", 4'b1000, 4'b0100, 2);
      step(4'b0000, 0, 0, 1);
      lit("late_aw_done", 4'b0000, 4'b0001, 3);

      // Round-robin with all requesting
      for (int t = 0; t < 5; t++) begin
         step(4'b1111, 0, 0, 0);
         lit("rr_grant", rr_exp[t], rr_exp[t], 3 + t);
         step(4'b1111, 1, 1, 0);
         step(4'b1111, 0, 0, 1);
         lit("rr_prio", 4'b0000, rr_exp[(t + 1) % 4], 4 + t);
      end

      // Randomized traffic, checked by the model every cycle
      for (int c = 0; c < 600; c++) begin
         step(N'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      end
      step(4'b0000, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/axi_write_slot_arbiter.md
# axi_write_slot_arbiter

Per-slave write-channel arbiter for the AXI4 crossbar. One instance sits in front of each slave port. It picks one of NUM_MASTER requesting masters by round-robin and holds that grant across the whole write transaction: AW, then the W burst up to WLAST, then the B response. It also exports the current one-hot priority vector, which drives the crossbar's combinational priority/select logic for this slave.

## Interface
- NUM_MASTER, 4, number of masters that can target this slave (≥1)
- CNT_WIDTH, 16, width of completed-transaction counter

- ACLK  in  1  clock, all state updates on rising edge
- ARESET  in  1  asynchronous, active-high reset
- req  in  NUM_MASTER  bit i = master i has AWVALID with an address decoded to this slave
- aw_hs  in  1  slave-side AWVALID & AWREADY of the granted master
- w_last_hs  in  1  slave-side WVALID & WREADY & WLAST of the granted master
- b_hs  in  1  slave-side BVALID & BREADY to the granted master
- grant  out  NUM_MASTER  one-hot grant, all zero when idle
- grant_valid  out  1  high when grant is non-zero
- prio  out  NUM_MASTER  one-hot round-robin pointer (highest-priority master)
- busy  out  1  high in any state except IDLE
- txn_count  out  CNT_WIDTH  count of completed transactions (b_hs while in RESP)

## Operation
- States: IDLE, ADDR, RESP.
- Flags: aw_done and w_done, cleared on entry to ADDR.
- IDLE:
  - If req ≠ 0, the winner is the first set bit of req scanning cyclically upward from the prio position, the prio bit itself included.
  - Register grant = one-hot(winner). Go to ADDR.
  - If req = 0, stay in IDLE with grant = 0.
- ADDR:
  - grant is held constant. req changes, including dropping to 0, are ignored.
  - aw_hs sets aw_done. w_last_hs sets w_done. W may complete before, with, or after AW.
  - Go to RESP in the cycle where (aw_done | aw_hs) & (w_done | w_last_hs) is true. Simultaneous aw_hs and w_last_hs in one cycle is legal and goes straight to RESP.
- RESP:
  - Hold grant.
  - On b_hs: go to IDLE, clear grant, set prio = grant rotated left by 1 (wraps MSB→bit 0), and increment txn_count, wrapping at 2^CNT_WIDTH.
- Handshake inputs outside their valid state are ignored:
  - aw_hs and w_last_hs in IDLE or RESP;
  - b_hs in IDLE or ADDR;
  - a second aw_hs after aw_done is already set.
- NUM_MASTER = 1: grant = 1 every transaction. prio stays 1.
- prio is always exactly one-hot. grant is one-hot or zero.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, grant = 0, grant_valid = 0, busy = 0, prio = 1 (master 0), txn_count = 0, flags = 0.
- Reset asserted mid-transaction aborts it with no completion count.
- req sampled at edge n in IDLE → grant, grant_valid and busy high after edge n (visible in cycle n+1).
- Completion sampled at edge m → state RESP from cycle m+1.
- b_hs sampled at edge k → grant = 0, busy = 0, prio/txn_count updated in cycle k+1. The earliest next grant is visible in cycle k+2.
- Minimum transaction occupancy: 3 cycles (ADDR with simultaneous aw_hs+w_last_hs, RESP with b_hs, IDLE).
- No combinational path from req to grant. All outputs are registered.

## Test plan
- Reset/single request:
  - After ARESET: grant = 0000, prio = 0001, txn_count = 0.
  - req = 0100 → next cycle grant = 0100.
  - aw_hs, w_last_hs, b_hs each in a separate cycle → txn_count = 1, prio = 1000, grant = 0000.
- Round-robin fairness: req = 1111 held with NUM_MASTER = 4, and each transaction completed → grants in order 0001, 0010, 0100, 1000, 0001; prio after each is the next bit.
- Pointer skip/wrap: prio = 1000, req = 0110 → grant = 0010; after b_hs prio = 0100.
- Handshake ordering:
  - w_last_hs two cycles before aw_hs → RESP the cycle after aw_hs.
  - aw_hs and w_last_hs in the same cycle → RESP next cycle.
  - b_hs pulsed during ADDR → ignored; grant held.
- Grant stability: req drops to 0000 during ADDR → grant unchanged until b_hs in RESP; then grant = 0000 and the state returns to IDLE.
- Async reset mid-RESP: ARESET pulsed between edges → grant = 0 immediately; txn_count unchanged from its pre-transaction value; prio = 0001.
